// File: rtl/inst_fetch_if.sv
// inst_fetch_if: bundles the signals of the fetch stage other than clk/reset.
//   master : the fetch stage (inst_fetch)
//   slave  : its environment (instruction memory, execute redirect, decode)
// Signals:
//   valid        run enable for new fetch requests
//   imem_req     instruction memory request, held until imem_ack
//   imem_addr    request address, stable while imem_req is high
//   imem_ack     one-cycle response strobe, imem_rdata valid with it
//   imem_rdata   fetched instruction word
//   redirect     one-cycle redirect pulse from execute
//   redirect_pc  redirect target (low two bits ignored)
//   stall_f_id   decode cannot accept this cycle
//   inst         instruction to decode
//   inst_pc      PC of inst
//   inst_valid   inst/inst_pc valid
interface inst_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              stall_f_id;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;

  modport master (
    input  valid, imem_ack, imem_rdata, redirect, redirect_pc, stall_f_id,
    output imem_req, imem_addr, inst, inst_pc, inst_valid
  );

  modport slave (
    output valid, imem_ack, imem_rdata, redirect, redirect_pc, stall_f_id,
    input  imem_req, imem_addr, inst, inst_pc, inst_valid
  );
endinterface

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage feeding decode.
// Holds the PC, issues one outstanding request at a time to instruction
// memory, buffers returned words together with their PCs in a small FIFO
// and presents the FIFO head to decode with a valid/stall handshake.
// A redirect flushes buffered and in-flight instructions and restarts at
// the target address.
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous, active-low reset
//   bus    inst_fetch_if.master (memory, redirect and decode signals)
// Optional build macro IFETCH_BYPASS_EN: when defined, a word returning
// while the FIFO is empty is shown to decode in the same cycle as its ack
// and is only buffered if decode stalls.
module inst_fetch #(
  parameter int                ADDR_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input logic          clk,
  input logic          reset,
  inst_fetch_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  req_addr;
  logic [ADDR_W+31:0] fifo_mem [FIFO_DEPTH];
  logic [ADDR_W+31:0] head;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   count_after_pop;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               fifo_push;
  logic               ack_ok;
  logic               issue;
  logic [ADDR_W-1:0]  redirect_target;

  assign fifo_empty      = (fifo_count == '0);
  assign head            = fifo_mem[rd_ptr];
  assign redirect_target = {bus.redirect_pc[ADDR_W-1:2], 2'b00};

  // A word is accepted only in WAIT; a same-cycle redirect drops it.
  assign ack_ok   = (state == S_WAIT) && bus.imem_ack && !bus.redirect;
  assign fifo_pop = !fifo_empty && !bus.stall_f_id;

  // Issue is judged against the occupancy left after this cycle's pop, and
  // never in a redirect cycle since pc is about to change.
  assign count_after_pop = fifo_count - {{(CNT_W-1){1'b0}}, fifo_pop};
  assign issue = (state == S_IDLE) && bus.valid && !bus.redirect &&
                 (count_after_pop < DEPTH_C);

  assign bus.imem_req  = (state != S_IDLE);
  assign bus.imem_addr = req_addr;

`ifdef IFETCH_BYPASS_EN
  logic bypass_hit;

  // Empty FIFO and a good ack: hand the word straight to decode, and only
  // keep it if decode is stalled.
  assign bypass_hit     = ack_ok && fifo_empty;
  assign fifo_push      = ack_ok && !(bypass_hit && !bus.stall_f_id);
  assign bus.inst_valid = !fifo_empty || bypass_hit;
  assign bus.inst       = !fifo_empty ? head[31:0] :
                          (bypass_hit ? bus.imem_rdata : 32'd0);
  assign bus.inst_pc    = !fifo_empty ? head[ADDR_W+31:32] :
                          (bypass_hit ? pc : '0);
`else
  // Registered-only path: decode sees the FIFO head, zero when empty.
  assign fifo_push      = ack_ok;
  assign bus.inst_valid = !fifo_empty;
  assign bus.inst       = fifo_empty ? 32'd0 : head[31:0];
  assign bus.inst_pc    = fifo_empty ? '0 : head[ADDR_W+31:32];
`endif

  // Fetch control. A redirect always wins: it loads the new pc and abandons
  // any outstanding request. If the memory has not answered yet we sit in
  // KILL holding the old address until the ack, then throw the data away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
    end else if (bus.redirect) begin
      pc <= redirect_target;
      if (state == S_IDLE || bus.imem_ack) begin
        state <= S_IDLE;
      end else begin
        state <= S_KILL;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            state    <= S_WAIT;
            req_addr <= pc;
          end
        end
        S_WAIT: begin
          if (bus.imem_ack) begin
            state <= S_IDLE;
            pc    <= pc + ADDR_W'(4);
          end
        end
        S_KILL: begin
          if (bus.imem_ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Buffer storage; entries past the head are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= {pc, bus.imem_rdata};
    end
  end

  // Buffer pointers and occupancy; a redirect empties it on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (bus.redirect) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage directly upstream of decode (id).
- Holds the PC and issues one-outstanding requests to instruction memory.
- Buffers returned words with their PCs in a small FIFO and presents them to decode with a valid/stall handshake.
- Accepts branch/jump redirects from later stages: flushes buffered and in-flight instructions, restarts at the target.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width.
- FIFO_DEPTH, 4, instruction buffer entries (power of 2, >=2).
- RESET_PC, 32'h0000_0000, PC value loaded at reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- valid  in  1  run enable; new fetch requests are issued only while high.
- imem_req  out  1  instruction memory request, held until imem_ack.
- imem_addr  out  ADDR_W  request address; stable while imem_req is high.
- imem_ack  in  1  one-cycle response strobe; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- redirect  in  1  one-cycle redirect pulse from execute.
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] are forced to 0.
- stall_f_id  in  1  decode cannot accept this cycle.
- inst  out  32  instruction to decode.
- inst_pc  out  ADDR_W  PC of inst.
- inst_valid  out  1  inst/inst_pc valid; consumed on inst_valid && !stall_f_id.

Behaviour:
- Reset (async assert, sync deassert):
  - pc=RESET_PC, FIFO empty, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- FSM states:
  - IDLE: if valid && (fifo_count < FIFO_DEPTH), assert imem_req with imem_addr=pc and go to WAIT.
  - WAIT: imem_req=1, imem_addr stable.
    - On imem_ack: push {pc, imem_rdata}, then pc=pc+4 (mod 2^ADDR_W, so 0xFFFF_FFFC wraps to 0).
    - Then go to IDLE.
  - KILL: entered on redirect while in WAIT without imem_ack that cycle. Keep imem_req=1 and the old address until imem_ack. Discard the data, then go to IDLE. No push, pc unchanged.
- Throughput: one request per two cycles (IDLE->WAIT). Issue is decided in IDLE against the count after that cycle's pop.
- Buffer: no bypass. An ack in cycle N makes the word visible on inst at cycle N+1. inst/inst_pc always show the FIFO head. inst_valid = FIFO non-empty.
- Pop: on inst_valid && !stall_f_id. Push and pop in the same cycle leave the count unchanged.
- Full: no request is issued while fifo_count == FIFO_DEPTH. At most one request is outstanding, and issue requires space, so overflow is impossible.
- Redirect (highest priority, any state):
  - FIFO cleared the same edge; inst_valid=0 next cycle.
  - pc = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - Redirect + imem_ack in the same cycle: data dropped, go to IDLE.
  - Redirect + pop in the same cycle: flush wins.
  - Redirect in KILL: update pc, stay in KILL.
- valid low: no new issue from IDLE. An outstanding request completes normally and decode still drains the FIFO.
- Reset mid-request: imem_req drops asynchronously. Memory must abandon the request on reset.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty and imem_ack arrives in WAIT with no redirect, inst=imem_rdata, inst_pc=pc and inst_valid=1 combinationally in the same cycle.
  - If !stall_f_id the word is consumed and not pushed; otherwise it is pushed.
  - Ack-to-decode latency is 0 cycles.
- Undefined: registered-only path as above, latency 1 cycle.

Test Plan:
- Reset release, valid=1, memory acks 1 cycle after req, stall_f_id=0 -> imem_addr sequence 0,4,8,...; inst_pc follows 0,4,8; inst_valid first high 1 cycle after the first ack.
- stall_f_id=1 held -> exactly 4 words buffered (PCs 0..0xC); imem_req stays 0 while full. Release stall -> words pop in order, fetch resumes at 0x10.
- Redirect to 0x103 while in WAIT with ack delayed 3 cycles -> imem_req held to the ack on the old address; data discarded; next request at 0x100; FIFO empty right after the redirect.
- Redirect to 0x200 in the same cycle as imem_ack and a pop -> no push, inst_valid=0 next cycle, next imem_addr=0x200.
- PC at 0xFFFF_FFFC fetched -> next imem_addr=0; inst_pc=0xFFFF_FFFC then 0.
- Reset asserted mid-WAIT and while FIFO holds 2 words -> imem_req, inst_valid drop immediately; after release, fetch restarts at RESET_PC.
